uart_rx_cfg: RTL

Parametrised UART receiver. Supports configurable data width, oversampling rate, runtime parity mode and 1/2 stop bits, and reports parity and framing errors. Includes an input synchroniser and false-start rejection. Sits between the pad-side RX line and the UART RX FIFO, driven by the shared baud-rate tick generator.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_cfg.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity modes, tick counter sizing.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver state encodings
  localparam int ST_IDLE   = 0;
  localparam int ST_START  = 1;
  localparam int ST_DATA   = 2;
  localparam int ST_PARITY = 3;
  localparam int ST_STOP   = 4;

  // Runtime parity modes; 2'b11 is reserved and behaves like PAR_NONE
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Width of a counter that spans 0..sb_tick-1
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > 1) ? $clog2(sb_tick) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
// Latency: 2 i_clock cycles from i_d to o_q.
// Backpressure: none; free-running.
// Ports: i_clock, i_reset (sync, active-high), i_d (async in), o_q (synchronised out).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: DBIT data bits LSB first, runtime parity (none/even/odd), 1 or 2 stop bits.
// Latency: 2-cycle input sync; o_rx_done_tick the cycle after the tick that samples the last stop bit.
// Backpressure: none; each frame is delivered once, consumer must take it on o_rx_done_tick.
// Ports: i_clock, i_reset (sync, active-high), i_rx (async line, idle high), i_s_tick (oversample tick),
//        i_parity_mode, i_two_stop (latched at frame start); o_rx_done_tick, o_data, o_parity_err,
//        o_frame_err (held until next done), o_busy (not IDLE).
// Build option: UART_RX_MAJORITY_EN votes each bit over counts SB_TICK/2-1..SB_TICK/2+1 and
//               moves every decision (and done) one tick later.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 3
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  input  logic [1:0]      i_parity_mode,
  input  logic            i_two_stop,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_data,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int CW = tick_cnt_width(SB_TICK);
  localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_CNT = SB_TICK / 2 + 1;
`else
  localparam int DEC_CNT = SB_TICK / 2;
`endif
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC_CNT);
  localparam logic [CW-1:0] CNT_END  = CW'(SB_TICK - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DBIT - 1);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE   = NB_STATE'(ST_IDLE),
    S_START  = NB_STATE'(ST_START),
    S_DATA   = NB_STATE'(ST_DATA),
    S_PARITY = NB_STATE'(ST_PARITY),
    S_STOP   = NB_STATE'(ST_STOP)
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [1:0]      mode_q, mode_d;
  logic            two_q, two_d;
  logic            stop2_q, stop2_d;     // currently in the second stop bit
  logic            perr_q, perr_d;       // parity result of the frame in flight
  logic            ferr_q, ferr_d;       // a stop bit already sampled low
  logic [DBIT-1:0] data_q, data_d;
  logic            perr_out_q, perr_out_d;
  logic            ferr_out_q, ferr_out_d;
  logic            done_q, done_d;

  logic rx_s;
  logic bit_val;
  logic at_dec;
  logic at_end;
  logic par_en;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two early samples; the third vote is the live rx_s at the decision tick.
  logic s0_q, s1_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else if (i_s_tick) begin
      if (cnt_q == CW'(SB_TICK / 2 - 1)) s0_q <= rx_s;
      if (cnt_q == CW'(SB_TICK / 2))     s1_q <= rx_s;
    end
  end

  assign bit_val = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign at_dec = i_s_tick && (cnt_q == CNT_DEC);
  assign at_end = i_s_tick && (cnt_q == CNT_END);
  assign par_en = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    two_d      = two_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    done_d     = 1'b0;

    if (i_s_tick && (state_q != S_IDLE))
      cnt_d = at_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          mode_d  = i_parity_mode;
          two_d   = i_two_stop;
          stop2_d = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        // Line back high mid start bit: noise, drop silently
        if (at_dec && bit_val) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (at_dec)
          shreg_d = {bit_val, shreg_q[DBIT-1:1]};
        if (at_end) begin
          if (idx_q == IDX_LAST)
            state_d = par_en ? S_PARITY : S_STOP;
          else
            idx_d = idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (at_dec)
          perr_d = (mode_q == PAR_ODD) ? ~(^shreg_q ^ bit_val) : (^shreg_q ^ bit_val);
        if (at_end)
          state_d = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (stop2_q || !two_q) begin
            // Final stop bit: publish and leave mid-bit so a following start edge is caught
            data_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q | ~bit_val;
            done_d     = 1'b1;
            state_d    = S_IDLE;
            cnt_d      = '0;
          end else begin
            ferr_d = ferr_q | ~bit_val;
          end
        end else if (at_end) begin
          stop2_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      mode_q     <= PAR_NONE;
      two_q      <= 1'b0;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      mode_q     <= mode_d;
      two_q      <= two_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      done_q     <= done_d;
    end
  end

  assign o_rx_done_tick = done_q;
  assign o_data         = data_q;
  assign o_parity_err   = perr_out_q;
  assign o_frame_err    = ferr_out_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule
